// File: rtl/vga_timing_gen.sv
// vga_timing_gen: lock-gated VGA raster timing generator.
// A fetch stream leads the display stream by PREFETCH cycles.
module vga_timing_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PREFETCH = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  output logic [9:0] fx,
  output logic [9:0] fy,
  output logic       fde,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       hs,
  output logic       vs,
  output logic       sof,
  output logic       vbl
);

  localparam logic [9:0] HV  = 10'(H_VIS);
  localparam logic [9:0] HS0 = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS1 = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] HT1 =
    10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VV  = 10'(V_VIS);
  localparam logic [9:0] VS0 = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS1 = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] VT1 =
    10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  // One raster position as it travels down the pipe.
  // hs/vs here are active-high terms; v marks lk valid.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       v;
  } px_t;

  logic       s1;
  logic       lk;
  logic [9:0] hc;
  logic [9:0] vc;
  px_t        f;
  px_t        d;

  // Two-flop synchronizer for the PLL lock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      lk <= 1'b0;
    end else begin
      s1 <= locked;
      lk <= s1;
    end
  end

  // Raster counters, held at the origin while unlocked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!lk) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == HT1) begin
      hc <= '0;
      vc <= (vc == VT1) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // Fetch stage: coordinates plus sync terms, blanked when unlocked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      f <= '0;
    end else begin
      f.x  <= lk ? hc : '0;
      f.y  <= lk ? vc : '0;
      f.de <= lk && (hc < HV) && (vc < VV);
      f.hs <= lk && (hc >= HS0) && (hc < HS1);
      f.vs <= lk && (vc >= VS0) && (vc < VS1);
      f.v  <= lk;
    end
  end

  generate
    if (PREFETCH == 0) begin : g_bypass
      assign d = f;
    end else begin : g_pipe
      px_t p [PREFETCH];

      // Delay line covering video RAM read latency.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PREFETCH; i++) p[i] <= '0;
        end else begin
          p[0] <= f;
          for (int i = 1; i < PREFETCH; i++) p[i] <= p[i-1];
        end
      end

      assign d = p[PREFETCH-1];
    end
  endgenerate

  assign fx  = f.x;
  assign fy  = f.y;
  assign fde = f.de;
  assign x   = d.x;
  assign y   = d.y;
  assign de  = d.de;
  assign hs  = d.hs ~^ SYNC_POL;
  assign vs  = d.vs ~^ SYNC_POL;
  assign sof = d.de && (d.x == '0) && (d.y == '0);
  assign vbl = d.v && (d.x == '0) && (d.y == VV);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA timing generator.
// Default build, a PREFETCH=0 build and a tiny SYNC_POL=1 build.
module tb_vga_timing_gen;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic locked = 1'b0;

  logic [9:0] fx, fy, x, y;
  logic fde, de, hs, vs, sof, vbl;

  logic [9:0] z_fx, z_fy, z_x, z_y;
  logic z_fde, z_de, z_hs, z_vs, z_sof, z_vbl;

  logic [9:0] t_fx, t_fy, t_x, t_y;
  logic t_fde, t_de, t_hs, t_vs, t_sof, t_vbl;

  int n_chk = 0;
  int n_fail = 0;
  int zmis = 0;

  always #20 clock = ~clock;

  vga_timing_gen dut (
    .clock(clock), .reset_n(reset_n), .locked(locked),
    .fx(fx), .fy(fy), .fde(fde), .x(x), .y(y), .de(de),
    .hs(hs), .vs(vs), .sof(sof), .vbl(vbl)
  );

  vga_timing_gen #(.PREFETCH(0)) u_z (
    .clock(clock), .reset_n(reset_n), .locked(locked),
    .fx(z_fx), .fy(z_fy), .fde(z_fde), .x(z_x), .y(z_y),
    .de(z_de), .hs(z_hs), .vs(z_vs), .sof(z_sof), .vbl(z_vbl)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .PREFETCH(3)
  ) u_t (
    .clock(clock), .reset_n(reset_n), .locked(locked),
    .fx(t_fx), .fy(t_fy), .fde(t_fde), .x(t_x), .y(t_y),
    .de(t_de), .hs(t_hs), .vs(t_vs), .sof(t_sof), .vbl(t_vbl)
  );

  typedef struct {
    logic       lk_in;
    logic       fde;
    logic [9:0] fx;
    logic       de;
    logic [9:0] x;
    logic       sof;
    logic       hsvs;
    logic       z_de;
    logic       z_sof;
    logic       t_sof;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 6; i++) begin
      locked = tbl[i].lk_in;
      adv();
      chk($sformatf("%s%0d_fde", tag, i), fde, tbl[i].fde);
      chk($sformatf("%s%0d_fx", tag, i), fx, tbl[i].fx);
      chk($sformatf("%s%0d_de", tag, i), de, tbl[i].de);
      chk($sformatf("%s%0d_x", tag, i), x, tbl[i].x);
      chk($sformatf("%s%0d_y", tag, i), y, 0);
      chk($sformatf("%s%0d_sof", tag, i), sof, tbl[i].sof);
      chk($sformatf("%s%0d_hs", tag, i), hs, tbl[i].hsvs);
      chk($sformatf("%s%0d_vs", tag, i), vs, tbl[i].hsvs);
      chk($sformatf("%s%0d_zde", tag, i), z_de, tbl[i].z_de);
      chk($sformatf("%s%0d_zsof", tag, i), z_sof, tbl[i].z_sof);
      chk($sformatf("%s%0d_tsof", tag, i), t_sof, tbl[i].t_sof);
    end
  endtask

  // Zero-lag build: display outputs must track the fetch outputs.
  always @(negedge clock) begin
    if (reset_n && (z_x !== z_fx || z_y !== z_fy || z_de !== z_fde))
      zmis++;
  end

  initial begin
    int found, n, xerr;
    int dec, hsc, hpul, hbad, run, vsc, vsx, vsy;
    int sofc, sof2, vblc, vb1, vb2;
    logic hs_prev, vs_prev;

    // edge k after locked rises: lk at 2, fetch at 3, display at 5
    tbl[0] = '{1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 10'd0, 1'b0, 10'd0, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 10'd1, 1'b0, 10'd0, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 10'd2, 1'b1, 10'd0, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 10'd3, 1'b1, 10'd1, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b1};

    adv();
    adv();
    chk("rst_de", de, 0);
    chk("rst_hs", hs, 1);
    reset_n = 1'b1;
    run_table("su");

    // Horizontal placement on line 10.
    found = 0;
    for (int i = 0; i < 10000 && found == 0; i++) begin
      adv();
      if (de && x == 0 && y == 10) found = 1;
    end
    chk("find_line10", found, 1);
    n = 1;
    xerr = 0;
    while (de && n < 700) begin
      adv();
      if (de) begin
        if (x !== 10'(n) || y !== 10'd10) xerr++;
        n++;
      end
    end
    chk("de_len", n, 640);
    chk("x_gaps", xerr, 0);
    n = 0;
    while (!de && hs && n < 1000) begin
      n++;
      adv();
    end
    chk("fp_len", n, 16);
    n = 0;
    while (!hs && n < 1000) begin
      n++;
      adv();
    end
    chk("hs_len", n, 96);
    n = 0;
    while (!de && n < 1000) begin
      n++;
      adv();
    end
    chk("bp_len", n, 48);
    chk("next_x", x, 0);
    chk("next_y", y, 11);

    // Lock drop at (300, 12).
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      adv();
      if (de && x == 300 && y == 12) found = 1;
    end
    chk("find_drop", found, 1);
    locked = 1'b0;
    adv();
    chk("drop1_fde", fde, 1);
    adv();
    chk("drop2_fde", fde, 1);
    adv();
    chk("drop3_fde", fde, 0);
    chk("drop3_fx", fx, 0);
    chk("drop3_fy", fy, 0);
    chk("drop3_de", de, 1);
    adv();
    chk("drop4_de", de, 1);
    adv();
    chk("drop5_de", de, 0);
    chk("drop5_x", x, 0);
    chk("drop5_y", y, 0);
    chk("drop5_hs", hs, 1);
    chk("drop5_vs", vs, 1);
    chk("drop5_sof", sof, 0);
    for (int i = 0; i < 5; i++) adv();
    locked = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      adv();
      if (k == 3) begin
        chk("relk3_fde", fde, 1);
        chk("relk3_fx", fx, 0);
        chk("relk3_fy", fy, 0);
      end
      if (k == 4) chk("relk4_sof", sof, 0);
      if (k == 5) begin
        chk("relk5_sof", sof, 1);
        chk("relk5_x", x, 0);
        chk("relk5_y", y, 0);
      end
    end

    // Asynchronous reset between edges, mid-line.
    for (int i = 0; i < 37; i++) adv();
    #6;
    reset_n = 1'b0;
    #1;
    chk("ar_fx", fx, 0);
    chk("ar_fy", fy, 0);
    chk("ar_fde", fde, 0);
    chk("ar_x", x, 0);
    chk("ar_y", y, 0);
    chk("ar_de", de, 0);
    chk("ar_hs", hs, 1);
    chk("ar_vs", vs, 1);
    chk("ar_sof", sof, 0);
    chk("ar_vbl", vbl, 0);
    chk("ar_ths", t_hs, 0);
    chk("ar_tvs", t_vs, 0);
    adv();
    chk("ar_held_de", de, 0);
    reset_n = 1'b1;
    run_table("rr");

    // Two full frames of the tiny build (15 x 10 raster).
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      adv();
      if (t_sof) found = 1;
    end
    chk("find_tsof", found, 1);
    dec = 0; hsc = 0; hpul = 0; hbad = 0; run = 0;
    vsc = 0; vsx = -1; vsy = -1;
    sofc = 0; sof2 = -1; vblc = 0; vb1 = -1; vb2 = -1;
    hs_prev = 1'b0;
    vs_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (t_de) dec++;
      if (t_hs) begin
        hsc++;
        run++;
        if (!hs_prev) hpul++;
      end else begin
        if (hs_prev && run != 3) hbad++;
        run = 0;
      end
      if (t_vs) begin
        vsc++;
        if (!vs_prev && vsx < 0) begin
          vsx = t_x;
          vsy = t_y;
        end
      end
      if (t_sof) begin
        sofc++;
        if (sofc == 2) sof2 = i;
      end
      if (t_vbl) begin
        vblc++;
        if (vblc == 1) vb1 = i;
        else vb2 = i;
      end
      hs_prev = t_hs;
      vs_prev = t_vs;
      adv();
    end
    chk("fr_de", dec, 96);
    chk("fr_hs_cyc", hsc, 60);
    chk("fr_hs_pul", hpul, 20);
    chk("fr_hs_wid", hbad, 0);
    chk("fr_vs_cyc", vsc, 60);
    chk("fr_vs_x", vsx, 0);
    chk("fr_vs_y", vsy, 7);
    chk("fr_sof_n", sofc, 2);
    chk("fr_sof_gap", sof2, 150);
    chk("fr_vbl_n", vblc, 2);
    chk("fr_vbl_pos", vb1, 90);
    chk("fr_vbl_gap", vb2 - vb1, 150);

    chk("p0_mirror", zmis, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
